// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline interlock for a 5-stage MIPS-style core. It detects load-use
//   hazards and accesses to HI/LO while a multiply/divide is still running.
//   It stalls or flushes the front end, and counts the cycles in which the PC
//   was held.
//
// Ports
//   CLK              in   clock, all state on posedge
//   RST              in   synchronous active-high reset
//   ID_IR[31:0]      in   instruction in the IF/ID register
//   EX_memread       in   EX-stage instruction is a load
//   EX_rt[4:0]       in   destination register of the EX-stage load
//   EX_branch_taken  in   branch/jump resolved taken in EX
//   IF_write         out  IF/ID load enable
//   PC_write         out  PC load enable
//   ID_bubble        out  zero ID control bits going into ID/EX
//   IF_flush         out  load NOP into IF/ID
//   MD_busy          out  HI/LO result not yet available
//   stall_cycles     out  saturating count of cycles with PC_write=0
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ID_IR,
  input  logic        EX_memread,
  input  logic [4:0]  EX_rt,
  input  logic        EX_branch_taken,
  output logic        IF_write,
  output logic        PC_write,
  output logic        ID_bubble,
  output logic        IF_flush,
  output logic        MD_busy,
  output logic [31:0] stall_cycles
);

  localparam logic [15:0] MulLat = MUL_LAT[15:0];
  localparam logic [15:0] DivLat = DIV_LAT[15:0];

  logic [15:0] r_md_cnt;
  logic [31:0] r_stall_cycles;
  // Set for the cycle after a load-use stall: the bubble is then in EX, so the
  // same load must not stall ID a second time.
  logic        r_lu_stalled;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_reads_rt;
  logic       w_is_mul;
  logic       w_is_div;
  logic       w_hilo_rd;
  logic       w_busy;
  logic       w_load_use;
  logic       w_md_hazard;
  logic       w_md_issue;
  logic       w_unused;

  assign w_op     = ID_IR[31:26];
  assign w_rs     = ID_IR[25:21];
  assign w_rt     = ID_IR[20:16];
  assign w_funct  = ID_IR[5:0];
  assign w_unused = ^ID_IR[15:6];

  assign w_reads_rt = (w_op == 6'h00) || (w_op == 6'h04) || (w_op == 6'h05) ||
                      (w_op == 6'h28) || (w_op == 6'h29) || (w_op == 6'h2B);

  assign w_is_mul  = (w_op == 6'h00) && ((w_funct == 6'h18) || (w_funct == 6'h19));
  assign w_is_div  = (w_op == 6'h00) && ((w_funct == 6'h1A) || (w_funct == 6'h1B));
  assign w_hilo_rd = (w_op == 6'h00) && ((w_funct == 6'h10) || (w_funct == 6'h12));

  assign w_busy = (r_md_cnt != 16'd0);

  assign w_load_use = EX_memread && (EX_rt != 5'd0) && !r_lu_stalled &&
                      ((EX_rt == w_rs) || (w_reads_rt && (EX_rt == w_rt)));

  assign w_md_hazard = w_busy && (w_is_mul || w_is_div || w_hilo_rd);

  // An md op can only issue in a normal cycle, so never while another is busy.
  assign w_md_issue = !EX_branch_taken && !w_load_use && !w_md_hazard &&
                      (w_is_mul || w_is_div);

  always_comb begin
    IF_write  = 1'b1;
    PC_write  = 1'b1;
    ID_bubble = 1'b0;
    IF_flush  = 1'b0;
    MD_busy   = w_busy;
    if (RST) begin
      ID_bubble = 1'b1;
      IF_flush  = 1'b1;
      MD_busy   = 1'b0;
    end else if (EX_branch_taken) begin
      ID_bubble = 1'b1;
      IF_flush  = 1'b1;
    end else if (w_load_use || w_md_hazard) begin
      IF_write  = 1'b0;
      PC_write  = 1'b0;
      ID_bubble = 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_md_cnt       <= 16'd0;
      r_stall_cycles <= 32'd0;
      r_lu_stalled   <= 1'b0;
    end else begin
      if (w_md_issue) begin
        r_md_cnt <= w_is_div ? DivLat : MulLat;
      end else if (w_busy) begin
        r_md_cnt <= r_md_cnt - 16'd1;
      end
      if (!PC_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      r_lu_stalled <= w_load_use && !EX_branch_taken;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int unsigned MulLat = 4;
  localparam int unsigned DivLat = 32;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ID_IR;
  logic        EX_memread;
  logic [4:0]  EX_rt;
  logic        EX_branch_taken;
  logic        IF_write, PC_write, ID_bubble, IF_flush, MD_busy;
  logic [31:0] stall_cycles;

  hazard_stall_ctrl #(.MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut (
    .CLK(CLK), .RST(RST), .ID_IR(ID_IR), .EX_memread(EX_memread), .EX_rt(EX_rt),
    .EX_branch_taken(EX_branch_taken), .IF_write(IF_write), .PC_write(PC_write),
    .ID_bubble(ID_bubble), .IF_flush(IF_flush), .MD_busy(MD_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: cycles left on the running md op, stall count, and
  // whether the previous cycle was a load-use stall.
  int          m_md_left = 0;
  logic [31:0] m_stalls  = 32'd0;
  bit          m_lu_prev = 1'b0;

  // ctrl vector order: {IF_write, PC_write, ID_bubble, IF_flush, MD_busy}
  localparam logic [4:0] CtlFlush  = 5'b11110;
  localparam logic [4:0] CtlStall  = 5'b00100;
  localparam logic [4:0] CtlNormal = 5'b11000;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                         input int funct);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt);
    return {6'(op), 5'(rs), 5'(rt), 16'h0010};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs (entered at a negedge), checks against the
  // model, advances the model, returns at the next negedge.
  task automatic step(input logic [31:0] ir, input logic mr, input logic [4:0] ert,
                      input logic bt, input logic rst, output logic [4:0] act);
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    bit          reads_rt, is_mul, is_div, hilo, busy, lu, mdh, stall;
    logic [4:0]  exp;
    ID_IR = ir; EX_memread = mr; EX_rt = ert; EX_branch_taken = bt; RST = rst;
    #1;
    op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; funct = ir[5:0];
    reads_rt = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    is_mul   = (op == 0) && (funct inside {6'h18, 6'h19});
    is_div   = (op == 0) && (funct inside {6'h1A, 6'h1B});
    hilo     = (op == 0) && (funct inside {6'h10, 6'h12});
    busy     = m_md_left > 0;
    lu       = mr && ert != 0 && !m_lu_prev && (ert == rs || (reads_rt && ert == rt));
    mdh      = busy && (is_mul || is_div || hilo);
    stall    = !rst && !bt && (lu || mdh);
    if (rst)        exp = CtlFlush;
    else if (bt)    exp = CtlFlush | 5'(busy);
    else if (stall) exp = CtlStall | 5'(busy);
    else            exp = CtlNormal | 5'(busy);
    act = {IF_write, PC_write, ID_bubble, IF_flush, MD_busy};
    check("ctrl", 32'(act), 32'(exp));
    check("stall_cycles", stall_cycles, m_stalls);
    if (rst) begin
      m_md_left = 0; m_stalls = 0; m_lu_prev = 0;
    end else begin
      if (!bt && !stall && (is_mul || is_div)) m_md_left = is_mul ? MulLat : DivLat;
      else if (m_md_left > 0) m_md_left--;
      if (stall && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      m_lu_prev = !bt && lu;
    end
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_ir();
    int rs = $urandom_range(0, 7);
    int rt = $urandom_range(0, 7);
    case ($urandom_range(0, 9))
      0: return r_type(rs, rt, 3, 'h20);
      1: return i_type('h23, rs, rt);
      2: return i_type('h2B, rs, rt);
      3: return i_type('h04, rs, rt);
      4: return r_type(rs, rt, 0, 'h18);
      5: return r_type(rs, rt, 0, 'h19);
      6: return r_type(rs, rt, 0, 'h1A);
      7: return r_type(rs, rt, 0, 'h1B);
      8: return r_type(0, 0, rt, 'h10);
      default: return r_type(0, 0, rt, 'h12);
    endcase
  endfunction

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic [4:0]  ert;
    logic        bt;
    logic        rst;
    logic [4:0]  exp;
  } vec_t;

  initial begin
    vec_t        vecs[10];
    logic [4:0]  act;
    logic [31:0] add_i, lw_i, sw_i, beq_i, mult_i, div_i, mflo_i;
    int          nstall;

    add_i  = r_type(5, 6, 3, 'h20);
    lw_i   = i_type('h23, 1, 6);
    sw_i   = i_type('h2B, 2, 6);
    beq_i  = i_type('h04, 7, 6);
    mult_i = r_type(1, 2, 0, 'h18);
    div_i  = r_type(1, 2, 0, 'h1A);
    mflo_i = r_type(0, 0, 4, 'h12);

    vecs[0] = '{add_i, 1, 5, 0, 1, CtlFlush};   // reset overrides hazard
    vecs[1] = '{32'h0, 1, 0, 0, 0, CtlNormal};  // EX_rt=0, rs=0
    vecs[2] = '{add_i, 1, 5, 0, 0, CtlStall};   // load-use on rs
    vecs[3] = '{add_i, 0, 5, 0, 0, CtlNormal};  // bubble now in EX
    vecs[4] = '{lw_i,  1, 6, 0, 0, CtlNormal};  // lw does not read rt
    vecs[5] = '{sw_i,  1, 6, 0, 0, CtlStall};   // sw reads rt
    vecs[6] = '{sw_i,  1, 6, 0, 0, CtlNormal};  // no re-trigger
    vecs[7] = '{add_i, 1, 5, 1, 0, CtlFlush};   // flush beats load-use
    vecs[8] = '{beq_i, 1, 6, 0, 0, CtlStall};   // beq reads rt
    vecs[9] = '{32'h0, 0, 0, 0, 0, CtlNormal};

    ID_IR = 0; EX_memread = 0; EX_rt = 0; EX_branch_taken = 0; RST = 1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].ir, vecs[i].mr, vecs[i].ert, vecs[i].bt, vecs[i].rst, act);
      check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
    end
    check("stall_after_vecs", stall_cycles, 32'd3);

    // mult then mflo: busy for MulLat cycles, mflo proceeds once idle
    step(mult_i, 0, 0, 0, 0, act);
    nstall = 0;
    for (int i = 0; i < 20; i++) begin
      step(mflo_i, 0, 0, 0, 0, act);
      if (act[3]) break;
      nstall++;
    end
    check("mflo_stall_len", 32'(nstall), 32'(MulLat));

    // flush while a divide is running keeps it running
    step(div_i, 0, 0, 0, 0, act);
    step(add_i, 0, 0, 1, 0, act);
    check("flush_busy", 32'(act), 32'(CtlFlush | 5'd1));
    step(32'h0, 0, 0, 0, 0, act);
    check("busy_after_flush", 32'(act[0]), 32'd1);
    for (int i = 0; i < 40 && MD_busy; i++) step(32'h0, 0, 0, 0, 0, act);
    check("div_drained", 32'(MD_busy), 32'd0);

    // reset on the 10th busy cycle of a divide
    step(div_i, 0, 0, 0, 0, act);
    for (int i = 0; i < 9; i++) step(32'h0, 0, 0, 0, 0, act);
    step(div_i, 1, 2, 0, 1, act);
    check("rst_held_ctrl", 32'(act), 32'(CtlFlush));
    step(32'h0, 0, 0, 0, 0, act);
    check("busy_after_rst", 32'(act[0]), 32'd0);
    check("stalls_after_rst", stall_cycles, 32'd0);

    // saturation: preload the counter near its maximum, then keep stalling
    step(div_i, 0, 0, 0, 0, act);
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    m_stalls = 32'hFFFF_FFFD;
    for (int i = 0; i < 6; i++) step(div_i, 0, 0, 0, 0, act);
    check("saturated", stall_cycles, 32'hFFFF_FFFF);
    step(32'h0, 0, 0, 0, 1, act);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(rand_ir(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0), act);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles HI/LO stay busy after a mult/multu issues; legal range 1..65535.
REQ-002 Parameter DIV_LAT, default 32: cycles HI/LO stay busy after a div/divu issues; legal range 1..65535.
REQ-003 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 ID_IR  in  32  instruction held in the IF/ID register.
REQ-006 EX_memread  in  1  EX-stage instruction is a load.
REQ-007 EX_rt  in  5  destination register of the EX-stage load.
REQ-008 EX_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-009 IF_write  out  1  IF/ID register load enable; 0 holds ID_pc4/ID_IR.
REQ-010 PC_write  out  1  PC load enable.
REQ-011 ID_bubble  out  1  zero ID control bits entering ID/EX (insert NOP).
REQ-012 IF_flush  out  1  load NOP (32'h0) into the IF/ID register.
REQ-013 MD_busy  out  1  multiply/divide result not yet available in HI/LO.
REQ-014 stall_cycles  out  32  count of cycles with PC_write=0.

Function
REQ-015 Decode from ID_IR: rs=[25:21], rt=[20:16], op=[31:26], funct=[5:0].
REQ-016 ID reads rt when op is 0, 4 (beq), 5 (bne), 0x28 (sb), 0x29 (sh) or 0x2B (sw); ID always reads rs.
REQ-017 Load-use hazard: EX_memread=1, EX_rt!=0, and EX_rt equals rs, or equals rt when rt is read.
REQ-018 md_op: op=0 and funct in {0x18,0x19} (mult class) or {0x1A,0x1B} (div class); hilo_rd: op=0 and funct in {0x10,0x12}.
REQ-019 MD hazard: MD_busy=1 and ID holds an md_op or a hilo_rd.
REQ-020 Outputs are combinational from current state and inputs; priority flush > load-use > MD hazard > normal.
REQ-021 Flush (EX_branch_taken=1): IF_flush=1, ID_bubble=1, IF_write=1, PC_write=1; no md issue that cycle.
REQ-022 Stall (load-use or MD hazard, no flush): IF_write=0, PC_write=0, ID_bubble=1, IF_flush=0.
REQ-023 Normal: IF_write=1, PC_write=1, ID_bubble=0, IF_flush=0.
REQ-024 A load-use stall lasts exactly 1 cycle per load; it must not re-trigger once the bubble occupies EX.
REQ-025 md issue: normal cycle with md_op in ID; at that edge, a 16-bit md_cnt loads MUL_LAT (mult class) or DIV_LAT (div class).
REQ-026 md_cnt decrements by 1 each edge while nonzero; MD_busy = (md_cnt != 0); MD_busy is therefore high for exactly LAT cycles after the issue edge.
REQ-027 Flush while MD_busy does not cancel md_cnt; the issued operation continues.
REQ-028 stall_cycles increments at each edge where PC_write=0 and RST=0; saturates at 32'hFFFFFFFF, no wrap.

Reset
REQ-029 RST=1 at an edge clears md_cnt and stall_cycles to 0.
REQ-030 While RST=1, outputs are IF_write=1, PC_write=1, IF_flush=1, ID_bubble=1, MD_busy=0 regardless of other inputs.
REQ-031 RST asserted mid-MD-operation aborts it: MD_busy=0 from the first cycle after the reset edge.

Verification
REQ-032 Load-use: EX_memread=1, EX_rt=5, ID_IR=add $3,$5,$6 -> one cycle IF_write=0, PC_write=0, ID_bubble=1; stall_cycles +1.
REQ-033 No false hazard: EX_memread=1, EX_rt=0, ID rs=0 -> normal outputs; EX_rt=6 with ID_IR=lw using rt=6 as destination -> no stall.
REQ-034 MD: issue mult (default MUL_LAT=4), then mflo in ID -> MD_busy high 4 cycles, stall while busy, mflo proceeds on first cycle MD_busy=0.
REQ-035 Priority: EX_branch_taken=1 with load-use hazard also present -> IF_flush=1, IF_write=1, PC_write=1, ID_bubble=1, no stall count.
REQ-036 Reset mid-divide: issue div, assert RST at 10th busy cycle -> MD_busy=0, stall_cycles=0 after reset edge; RST-held outputs per REQ-030.
REQ-037 Saturation: force stall_cycles near max via long MD stall with DIV_LAT=65535 across repeated divs in sim -> counter holds at 32'hFFFFFFFF.
